// File: rtl/imem_load_ctrl.sv
// Boot loader: streams program words into instruction memory, then releases the core.
// Define IMEM_LOAD_CHECKSUM_EN to add a word-XOR checksum check before run.
module imem_load_ctrl #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 256,
    parameter logic [XLEN-1:0] BASE_ADDR = '0,
    localparam int             CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [CNT_W-1:0] word_count_i,
`ifdef IMEM_LOAD_CHECKSUM_EN
    input  logic [XLEN-1:0]  checksum_i,
`endif
    input  logic             s_valid_i,
    input  logic [XLEN-1:0]  s_data_i,
    output logic             s_ready_o,
    input  logic [XLEN-1:0]  core_pc_i,
    output logic [XLEN-1:0]  imem_addr_o,
    output logic             imem_we_o,
    output logic [XLEN-1:0]  imem_wdata_o,
    output logic             core_rst_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] idx_q, cnt_q;
    logic             err_q, core_rst_q, done_q, s_ready_q;
    logic             hs, last_word, start_seen, count_ok;

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [XLEN-1:0]  acc_q, chk_q;
    logic             sum_ok;

    assign sum_ok = (acc_q == chk_q);
`endif

    assign hs         = s_valid_i & s_ready_q;
    assign last_word  = hs && (idx_q == cnt_q - CNT_W'(1));
    assign start_seen = start_i && (state_q == IDLE || state_q == RUN);
    assign count_ok   = (word_count_i != '0)
                     && (word_count_i <= CNT_W'(DEPTH));

    // Handshake-facing outputs are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            s_ready_q  <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            acc_q      <= '0;
            chk_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            s_ready_q  <= (state_d == LOAD);
            core_rst_q <= (state_d != RUN);
            done_q     <= (state_d == RUN);
            if (start_seen) begin
                if (count_ok) begin
                    cnt_q <= word_count_i;
                    idx_q <= '0;
                    err_q <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
                    acc_q <= '0;
                    chk_q <= checksum_i;
`endif
                end else begin
                    err_q <= 1'b1;
                end
            end
            if (hs) begin
                idx_q <= idx_q + CNT_W'(1);
`ifdef IMEM_LOAD_CHECKSUM_EN
                acc_q <= acc_q ^ s_data_i;
`endif
            end
`ifdef IMEM_LOAD_CHECKSUM_EN
            if (state_q == CHECK && !sum_ok) err_q <= 1'b1;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_seen && count_ok) state_d = LOAD;
            LOAD: begin
                if (last_word) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = RUN;
`endif
                end
            end
`ifdef IMEM_LOAD_CHECKSUM_EN
            CHECK: state_d = sum_ok ? RUN : IDLE;
`endif
            RUN:  if (start_seen && count_ok) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    // Loader owns the address port only on handshake cycles.
    always_comb begin
        imem_we_o    = hs;
        imem_wdata_o = s_data_i;
        imem_addr_o  = core_pc_i;
        if (hs) imem_addr_o = BASE_ADDR + (XLEN'(idx_q) << 2);
        busy_o       = (state_q == LOAD) || (state_q == CHECK);
        s_ready_o    = s_ready_q;
        core_rst_o   = core_rst_q;
        done_o       = done_q;
        err_o        = err_q;
    end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Randomized self-checking bench for imem_load_ctrl.
// Builds with or without IMEM_LOAD_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_imem_load_ctrl;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 256;
    localparam int          CNT_W = $clog2(DEPTH) + 1;
    localparam logic [31:0] BASE  = 32'h0;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic [CNT_W-1:0] word_count_i;
    logic             s_valid_i;
    logic [XLEN-1:0]  s_data_i;
    logic             s_ready_o;
    logic [XLEN-1:0]  core_pc_i;
    logic [XLEN-1:0]  imem_addr_o;
    logic             imem_we_o;
    logic [XLEN-1:0]  imem_wdata_o;
    logic             core_rst_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [XLEN-1:0]  checksum_i;
    logic             ck_force = 1'b0;
    logic [XLEN-1:0]  ck_val   = '0;
`endif

    int          ncmp  = 0;
    int          nfail = 0;
    logic [31:0] words[DEPTH];
    logic [31:0] tmem[DEPTH];
    logic        tm_clr = 1'b0;

    always #5 clk = ~clk;

    imem_load_ctrl #(
        .XLEN(XLEN), .DEPTH(DEPTH), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_i(start_i),
        .word_count_i(word_count_i),
`ifdef IMEM_LOAD_CHECKSUM_EN
        .checksum_i(checksum_i),
`endif
        .s_valid_i(s_valid_i),
        .s_data_i(s_data_i),
        .s_ready_o(s_ready_o),
        .core_pc_i(core_pc_i),
        .imem_addr_o(imem_addr_o),
        .imem_we_o(imem_we_o),
        .imem_wdata_o(imem_wdata_o),
        .core_rst_o(core_rst_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .err_o(err_o)
    );

    // Behavioural instruction memory fed by the write port.
    always @(posedge clk) begin
        if (tm_clr) begin
            foreach (tmem[i]) tmem[i] <= 32'hDEAD_BEEF;
        end else if (imem_we_o) begin
            tmem[imem_addr_o[9:2]] <= imem_wdata_o;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] xsum(input int n);
        logic [31:0] s = '0;
        for (int i = 0; i < n; i++) s ^= words[i];
        return s;
    endfunction

    task automatic do_start(input int n);
        start_i      = 1'b1;
        word_count_i = CNT_W'(n);
        tm_clr       = 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
        checksum_i   = ck_force ? ck_val : xsum(n);
`endif
        @(posedge clk); #1;
        start_i = 1'b0;
        tm_clr  = 1'b0;
    endtask

    // mode 0: valid held high, 1: toggling 1-0-1-0, 2: random with stray starts
    task automatic load_words(input int n, input int mode);
        int k   = 0;
        int cyc = 0;
        while (k < n && cyc < 2000) begin
            case (mode)
                0:       s_valid_i = 1'b1;
                1:       s_valid_i = (cyc % 2 == 0);
                default: s_valid_i = 1'($urandom_range(0, 1));
            endcase
            s_data_i  = s_valid_i ? words[k] : $urandom;
            core_pc_i = $urandom;
            if (mode == 2) begin
                start_i      = 1'($urandom_range(0, 1));
                word_count_i = CNT_W'($urandom_range(1, 8));
            end
            @(negedge clk);
            ncmp++;
            if (s_ready_o !== 1'b1) begin
                nfail++;
                $display("FAIL load_ready: got %b want 1 (k=%0d)", s_ready_o, k);
            end
            ncmp++;
            if (core_rst_o !== 1'b1 || done_o !== 1'b0 || busy_o !== 1'b1) begin
                nfail++;
                $display("FAIL load_status: rst/done/busy got %b%b%b want 101",
                         core_rst_o, done_o, busy_o);
            end
            ncmp++;
            if (imem_we_o !== s_valid_i) begin
                nfail++;
                $display("FAIL load_we: got %b want %b (k=%0d)", imem_we_o, s_valid_i, k);
            end
            ncmp++;
            if (s_valid_i) begin
                if (imem_addr_o !== BASE + 32'(4 * k) || imem_wdata_o !== words[k]) begin
                    nfail++;
                    $display("FAIL load_write: got %h/%h want %h/%h",
                             imem_addr_o, imem_wdata_o, BASE + 32'(4 * k), words[k]);
                end
                k++;
            end else if (imem_addr_o !== core_pc_i) begin
                nfail++;
                $display("FAIL stall_addr: got %h want %h", imem_addr_o, core_pc_i);
            end
            @(posedge clk); #1;
            cyc++;
        end
        s_valid_i = 1'b0;
        start_i   = 1'b0;
        ncmp++;
        if (k != n) begin
            nfail++;
            $display("FAIL load_timeout: got %0d words want %0d", k, n);
        end
    endtask

    task automatic expect_run();
`ifdef IMEM_LOAD_CHECKSUM_EN
        @(negedge clk);
        ncmp++;
        if (busy_o !== 1'b1 || core_rst_o !== 1'b1) begin
            nfail++;
            $display("FAIL check_cycle: busy/rst got %b%b want 11", busy_o, core_rst_o);
        end
        @(posedge clk); #1;
`endif
        @(negedge clk);
        ncmp++;
        if (core_rst_o !== 1'b0 || done_o !== 1'b1) begin
            nfail++;
            $display("FAIL run_entry: rst/done got %b%b want 01", core_rst_o, done_o);
        end
        ncmp++;
        if (busy_o !== 1'b0 || s_ready_o !== 1'b0 || err_o !== 1'b0) begin
            nfail++;
            $display("FAIL run_flags: busy/ready/err got %b%b%b want 000",
                     busy_o, s_ready_o, err_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_mem(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            core_pc_i = BASE + 32'(4 * i);
            #1;
            ncmp++;
            if (imem_addr_o !== core_pc_i) begin
                nfail++;
                $display("FAIL pc_mux: got %h want %h", imem_addr_o, core_pc_i);
            end
            ncmp++;
            if (tmem[imem_addr_o[9:2]] !== words[i]) begin
                nfail++;
                $display("FAIL mem_word[%0d]: got %h want %h",
                         i, tmem[imem_addr_o[9:2]], words[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_i = 1'b0; word_count_i = '0;
        s_valid_i = 1'b0; s_data_i = '0;
        core_pc_i = 32'h0000_1234;
`ifdef IMEM_LOAD_CHECKSUM_EN
        checksum_i = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        ncmp++;
        if (core_rst_o !== 1'b1 || s_ready_o !== 1'b0 || imem_we_o !== 1'b0) begin
            nfail++;
            $display("FAIL reset_a: rst/ready/we got %b%b%b want 100",
                     core_rst_o, s_ready_o, imem_we_o);
        end
        ncmp++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0) begin
            nfail++;
            $display("FAIL reset_b: busy/done/err got %b%b%b want 000",
                     busy_o, done_o, err_o);
        end
        ncmp++;
        if (imem_addr_o !== 32'h0000_1234) begin
            nfail++;
            $display("FAIL reset_addr: got %h want 00001234", imem_addr_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_load_basic();
        words[0] = 32'h0000_0013; words[1] = 32'h0010_0093;
        words[2] = 32'h0020_8113; words[3] = 32'h0020_81b3;
        do_start(4);
        load_words(4, 0);
        expect_run();
        check_mem(4);
    endtask

    task automatic test_load_stall();
        do_start(4);
        load_words(4, 1);
        expect_run();
        check_mem(4);
    endtask

    task automatic test_errors();
        int bad[2];
        bad[0] = 0;
        bad[1] = DEPTH + 1;
        pulse_reset();
        foreach (bad[b]) begin
            s_valid_i = 1'b1;
            s_data_i  = $urandom;
            do_start(bad[b]);
            repeat (3) begin
                @(negedge clk);
                ncmp++;
                if (err_o !== 1'b1 || imem_we_o !== 1'b0 || core_rst_o !== 1'b1) begin
                    nfail++;
                    $display("FAIL bad_count_%0d: err/we/rst got %b%b%b want 101",
                             bad[b], err_o, imem_we_o, core_rst_o);
                end
                ncmp++;
                if (s_ready_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
                    nfail++;
                    $display("FAIL bad_idle_%0d: ready/busy/done got %b%b%b want 000",
                             bad[b], s_ready_o, busy_o, done_o);
                end
                @(posedge clk); #1;
            end
        end
        s_valid_i = 1'b0;
        for (int i = 0; i < 2; i++) words[i] = $urandom;
        do_start(2);
        @(negedge clk);
        ncmp++;
        if (err_o !== 1'b0) begin
            nfail++;
            $display("FAIL err_clear: got %b want 0", err_o);
        end
        @(posedge clk); #1;
        load_words(2, 2);
        expect_run();
        check_mem(2);
    endtask

    task automatic test_run_mux();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            core_pc_i = (i == 5) ? 32'h8 : $urandom;
            #1;
            ncmp++;
            if (imem_addr_o !== core_pc_i || imem_we_o !== 1'b0) begin
                nfail++;
                $display("FAIL run_mux: got %h/%b want %h/0",
                         imem_addr_o, imem_we_o, core_pc_i);
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) words[i] = $urandom;
        do_start(3);
        @(negedge clk);
        ncmp++;
        if (core_rst_o !== 1'b1 || done_o !== 1'b0 || s_ready_o !== 1'b1 || busy_o !== 1'b1) begin
            nfail++;
            $display("FAIL restart: rst/done/ready/busy got %b%b%b%b want 1011",
                     core_rst_o, done_o, s_ready_o, busy_o);
        end
        @(posedge clk); #1;
        load_words(3, 0);
        expect_run();
        check_mem(3);
    endtask

    task automatic test_reset_midload();
        for (int i = 0; i < 4; i++) words[i] = $urandom;
        do_start(4);
        load_words(2, 0);
        s_valid_i = 1'b1;
        rst = 1'b1;
        #1;
        ncmp++;
        if (s_ready_o !== 1'b0 || core_rst_o !== 1'b1 || busy_o !== 1'b0) begin
            nfail++;
            $display("FAIL midload_rst: ready/rst/busy got %b%b%b want 010",
                     s_ready_o, core_rst_o, busy_o);
        end
        ncmp++;
        if (imem_we_o !== 1'b0 || done_o !== 1'b0) begin
            nfail++;
            $display("FAIL midload_we: we/done got %b%b want 00", imem_we_o, done_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        s_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) words[i] = $urandom;
        do_start(4);
        load_words(4, 2);
        expect_run();
        check_mem(4);
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            int n;
            n = (t == 5) ? DEPTH : int'($urandom_range(1, 16));
            for (int i = 0; i < n; i++) words[i] = $urandom;
            do_start(n);
            load_words(n, (t == 5) ? 0 : int'($urandom_range(0, 2)));
            expect_run();
            check_mem(n);
        end
    endtask

`ifdef IMEM_LOAD_CHECKSUM_EN
    task automatic test_checksum();
        pulse_reset();
        words[0] = 32'h13; words[1] = 32'h93; words[2] = 32'h33;
        ck_force = 1'b1;
        ck_val   = 32'hB3;
        do_start(3);
        load_words(3, 0);
        expect_run();
        ck_val = 32'h0;
        do_start(3);
        load_words(3, 0);
        @(negedge clk);
        @(posedge clk); #1;
        s_valid_i = 1'b1;
        @(negedge clk);
        ncmp++;
        if (err_o !== 1'b1 || core_rst_o !== 1'b1 || done_o !== 1'b0) begin
            nfail++;
            $display("FAIL ck_bad: err/rst/done got %b%b%b want 110",
                     err_o, core_rst_o, done_o);
        end
        ncmp++;
        if (busy_o !== 1'b0 || s_ready_o !== 1'b0 || imem_we_o !== 1'b0) begin
            nfail++;
            $display("FAIL ck_idle: busy/ready/we got %b%b%b want 000",
                     busy_o, s_ready_o, imem_we_o);
        end
        @(posedge clk); #1;
        s_valid_i = 1'b0;
        ck_force  = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_load_basic();
        test_load_stall();
        test_errors();
        test_run_mux();
        test_reset_midload();
        test_random();
`ifdef IMEM_LOAD_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
